// File: rtl/multiport_memory.sv
`default_nettype none
// ============================================================================
// multiport_memory: byte-writable RAM, N read ports, self-clearing sweep. Rev 1.0
// ============================================================================
module multiport_memory #(
  parameter int BITS       = 32,
  parameter int DEPTH      = 256,
  parameter int READ_PORTS = 2,
  parameter int REG_READ   = 0,
  parameter int BYPASS     = 1,
  localparam int AW        = $clog2(DEPTH),
  localparam int NB        = BITS / 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_req,
  input  logic                       write_en,
  input  logic [AW-1:0]              write_address,
  input  logic [NB-1:0]              byte_en,
  input  logic [BITS-1:0]            data_in,
  input  logic [READ_PORTS*AW-1:0]   read_address,
  output logic [READ_PORTS*BITS-1:0] data_out,
  output logic                       busy,
  output logic                       write_drop
);

  localparam logic [0:0]    CLEAR   = 1'b0;
  localparam logic [0:0]    READY   = 1'b1;
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

  logic [0:0]    state, state_next;
  logic [AW-1:0] count, count_next;
  logic          waddr_ok, write_any, write_ok;
  logic [BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      CLEAR: begin
        if (clear_req) begin
          count_next = '0;
        end else begin
          count_next = count + 1'b1;
          if (count == LAST) state_next = READY;
        end
      end
      READY: begin
        if (clear_req) begin
          count_next = '0;
          state_next = CLEAR;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  always_comb begin
    busy = (state == CLEAR);
  end

  assign waddr_ok  = ({1'b0, write_address} < DEPTH_W);
  assign write_any = write_en && (|byte_en);
  assign write_ok  = write_any && !busy && waddr_ok && !clear_req;

  // A write with no enabled bytes is a no-op, not a drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) write_drop <= 1'b0;
    else     write_drop <= write_any && !write_ok;
  end

  always_ff @(posedge clk) begin
    if (busy) begin
      mem[count] <= '0;
    end else if (write_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (byte_en[b]) mem[write_address][8*b +: 8] <= data_in[8*b +: 8];
      end
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
    logic [AW-1:0]   ra;
    logic [BITS-1:0] word, merged, value;

    assign ra = read_address[p*AW +: AW];

    always_comb begin
      word = '0;
      if ({1'b0, ra} < DEPTH_W) word = mem[ra];
      merged = word;
      if ((BYPASS != 0) && write_ok && (write_address == ra)) begin
        for (int b = 0; b < NB; b++) begin
          if (byte_en[b]) merged[8*b +: 8] = data_in[8*b +: 8];
        end
      end
      value = busy ? '0 : merged;
    end

    if (REG_READ != 0) begin : g_reg
      logic [BITS-1:0] q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= value;
      end
      // Masking the register output keeps the first cycle of a re-clear at zero.
      assign data_out[p*BITS +: BITS] = busy ? '0 : q;
    end else begin : g_comb
      assign data_out[p*BITS +: BITS] = value;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multiport_memory.sv
`default_nettype none
// ============================================================================
// tb_multiport_memory: vector table + scoreboard bench for multiport_memory. Rev 1.0
// ============================================================================
module tb_multiport_memory;

  logic        clk = 1'b0;
  logic        rst, clear_req, write_en;
  logic [7:0]  write_address;
  logic [3:0]  byte_en;
  logic [31:0] data_in;
  logic [15:0] read_address;
  logic [63:0] out0, out1, out2;
  logic        busy0, busy1, busy2, drop0, drop1, drop2;
  logic [3:0]  wa3, ra3;
  logic [31:0] out3;
  logic        busy3, drop3;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  multiport_memory dut0 (
    .clk(clk), .rst(rst), .clear_req(clear_req), .write_en(write_en),
    .write_address(write_address), .byte_en(byte_en), .data_in(data_in),
    .read_address(read_address), .data_out(out0), .busy(busy0), .write_drop(drop0));

  multiport_memory #(.BYPASS(0)) dut1 (
    .clk(clk), .rst(rst), .clear_req(clear_req), .write_en(write_en),
    .write_address(write_address), .byte_en(byte_en), .data_in(data_in),
    .read_address(read_address), .data_out(out1), .busy(busy1), .write_drop(drop1));

  multiport_memory #(.REG_READ(1)) dut2 (
    .clk(clk), .rst(rst), .clear_req(clear_req), .write_en(write_en),
    .write_address(write_address), .byte_en(byte_en), .data_in(data_in),
    .read_address(read_address), .data_out(out2), .busy(busy2), .write_drop(drop2));

  multiport_memory #(.DEPTH(12), .READ_PORTS(1)) dut3 (
    .clk(clk), .rst(rst), .clear_req(clear_req), .write_en(write_en),
    .write_address(wa3), .byte_en(byte_en), .data_in(data_in),
    .read_address(ra3), .data_out(out3), .busy(busy3), .write_drop(drop3));

  typedef struct {
    logic        we;
    logic [7:0]  wa;
    logic [3:0]  be;
    logic [31:0] din;
    logic [7:0]  ra0, ra1;
    logic [31:0] e0, e1, n0, n1;
    logic        drop;
  } vec_t;

  typedef struct {
    logic [31:0] d0, d1;
    logic        drop;
  } exp_t;

  vec_t vt [9];
  exp_t sbq [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setin(input logic we, input logic [7:0] wa, input logic [3:0] be,
                       input logic [31:0] din, input logic [7:0] r0, input logic [7:0] r1);
    write_en      = we;
    write_address = wa;
    byte_en       = be;
    data_in       = din;
    read_address  = {r1, r0};
  endtask

  task automatic count_fall(output int f0, output int f3);
    f0 = 0;
    f3 = 0;
    for (int n = 1; n <= 600 && (f0 == 0 || f3 == 0); n++) begin
      tick();
      if (!busy0 && f0 == 0) f0 = n;
      if (!busy3 && f3 == 0) f3 = n;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   f0, f3, fall;
    exp_t e;

    vt[0] = '{1'b1, 8'd5, 4'hF, 32'hAABBCCDD, 8'd5, 8'd6, 32'hAABBCCDD, 32'h0, 32'h0, 32'h0, 1'b0};
    vt[1] = '{1'b1, 8'd5, 4'h5, 32'h11223344, 8'd5, 8'd5, 32'hAA22CC44, 32'hAA22CC44, 32'hAABBCCDD, 32'hAABBCCDD, 1'b0};
    vt[2] = '{1'b0, 8'd0, 4'h0, 32'h0, 8'd5, 8'd9, 32'hAA22CC44, 32'h0, 32'hAA22CC44, 32'h0, 1'b0};
    vt[3] = '{1'b1, 8'd9, 4'hF, 32'hDEADBEEF, 8'd5, 8'd9, 32'hAA22CC44, 32'hDEADBEEF, 32'hAA22CC44, 32'h0, 1'b0};
    vt[4] = '{1'b1, 8'd9, 4'h0, 32'hFFFFFFFF, 8'd9, 8'd9, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vt[5] = '{1'b1, 8'd0, 4'h3, 32'h00001234, 8'd0, 8'd9, 32'h00001234, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0};
    vt[6] = '{1'b0, 8'd0, 4'h0, 32'h0, 8'd3, 8'd0, 32'h0, 32'h00001234, 32'h0, 32'h00001234, 1'b0};
    vt[7] = '{1'b1, 8'd3, 4'hF, 32'h12345678, 8'd3, 8'd3, 32'h12345678, 32'h12345678, 32'h0, 32'h0, 1'b0};
    vt[8] = '{1'b0, 8'd0, 4'h0, 32'h0, 8'd3, 8'd5, 32'h12345678, 32'hAA22CC44, 32'h12345678, 32'hAA22CC44, 1'b0};

    rst = 1'b1;
    clear_req = 1'b0;
    wa3 = 4'd0;
    ra3 = 4'd0;
    setin(1'b0, 8'd0, 4'h0, 32'h0, 8'd0, 8'd0);
    #1;
    check("reset busy", busy0, 1'b1);
    check("reset write_drop", drop0, 1'b0);
    check("reset reg data_out", out2, 64'h0);
    check("reset reg busy", busy2, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    count_fall(f0, f3);
    check("sweep length depth256", f0, 256);
    check("sweep length depth12", f3, 12);

    for (int a = 0; a < 256; a++) begin
      read_address = {8'(255 - a), 8'(a)};
      #1;
      check("cleared word", out0, 64'h0);
    end

    for (int i = 0; i < 9; i++) begin
      setin(vt[i].we, vt[i].wa, vt[i].be, vt[i].din, vt[i].ra0, vt[i].ra1);
      #2;
      check($sformatf("vec%0d bypass port0", i), out0[31:0], vt[i].e0);
      check($sformatf("vec%0d bypass port1", i), out0[63:32], vt[i].e1);
      check($sformatf("vec%0d nobypass port0", i), out1[31:0], vt[i].n0);
      check($sformatf("vec%0d nobypass port1", i), out1[63:32], vt[i].n1);
      sbq.push_back('{vt[i].e0, vt[i].e1, vt[i].drop});
      tick();
      e = sbq.pop_front();
      check($sformatf("vec%0d registered ports", i), out2, {e.d1, e.d0});
      check($sformatf("vec%0d write_drop", i), drop0, e.drop);
    end

    for (int i = 0; i < 4; i++) begin
      setin(1'b1, 8'(i), 4'hF, 32'h100 + i, 8'(i), 8'd0);
      tick();
    end
    setin(1'b0, 8'd0, 4'h0, 32'h0, 8'd2, 8'd3);
    #1;
    check("fill readback", out0, {32'h103, 32'h102});

    clear_req = 1'b1;
    setin(1'b1, 8'd7, 4'hF, 32'hFFFF, 8'd2, 8'd3);
    tick();
    clear_req = 1'b0;
    write_en  = 1'b0;
    check("drop on clear_req", drop0, 1'b1);
    check("busy after clear_req", busy0, 1'b1);
    fall = 0;
    for (int t = 1; t <= 600 && fall == 0; t++) begin
      if (t == 10) setin(1'b1, 8'd2, 4'hF, 32'hCAFEF00D, 8'd2, 8'd3);
      if (t == 20) clear_req = 1'b1;
      tick();
      write_en  = 1'b0;
      clear_req = 1'b0;
      if (t == 10) check("drop during sweep", drop0, 1'b1);
      if (t == 11) check("drop single pulse", drop0, 1'b0);
      if (t == 50) check("data_out zero while busy", out0, 64'h0);
      if (!busy0) fall = t;
    end
    check("re-clear with restart length", fall, 276);
    for (int i = 0; i < 4; i++) begin
      read_address = {8'(i ^ 1), 8'(i)};
      #1;
      check("re-cleared word", out0, 64'h0);
    end

    setin(1'b1, 8'd50, 4'hF, 32'h5A5A5A5A, 8'd0, 8'd0);
    wa3 = 4'd13;
    ra3 = 4'd13;
    #2;
    check("out-of-range read", out3, 32'h0);
    tick();
    check("out-of-range write drop", drop3, 1'b1);
    check("in-range write no drop", drop0, 1'b0);
    wa3 = 4'd11;
    ra3 = 4'd11;
    #2;
    check("last address bypass", out3, 32'h5A5A5A5A);
    tick();
    write_en = 1'b0;
    #1;
    check("last address stored", out3, 32'h5A5A5A5A);
    check("last address no drop", drop3, 1'b0);

    setin(1'b1, 8'd3, 4'hF, 32'h12345678, 8'd4, 8'd0);
    tick();
    setin(1'b0, 8'd0, 4'h0, 32'h0, 8'd3, 8'd0);
    #2;
    check("reg read before edge", out2[31:0], 32'h0);
    tick();
    check("reg read latency", out2[31:0], 32'h12345678);
    rst = 1'b1;
    #1;
    check("reg data_out on async rst", out2, 64'h0);
    check("busy on async rst", busy2, 1'b1);
    tick();
    rst = 1'b0;
    count_fall(f0, f3);
    check("sweep after mid-op rst", f0, 256);
    read_address = {8'd3, 8'd0};
    #1;
    check("word zero after mid-op rst", out0, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
